// File: rtl/caliptra_fpga_sync_apb_master.sv
// APB requester: takes one command from the FPGA sync register block, runs a SETUP/ACCESS
// transfer against the Caliptra APB slave (advanced only on clk_en cycles) and returns a response.
module caliptra_fpga_sync_apb_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned USER_W  = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              aclk,
   input  logic              rstn,
   input  logic              clk_en,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [2:0]        cmd_pprot,
   input  logic [USER_W-1:0] cmd_pauser,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic              busy,
   output logic [7:0]        err_count,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic [2:0]        PPROT,
   output logic [USER_W-1:0] PAUSER,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int unsigned CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit          HAS_TO    = (TIMEOUT != 0);
   localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_accept;
   logic              w_done;
   logic              w_to;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [2:0]        r_pprot;
   logic [USER_W-1:0] r_pauser;
   logic [DATA_W-1:0] r_rdata;
   logic              r_slverr;
   logic              r_timeout;
   logic [7:0]        r_err;

   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // PREADY is checked before the timeout so a same-cycle completion wins.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_done   = 1'b0;
      w_to     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_accept = 1'b1;
               w_next   = S_SETUP;
            end
         end
         S_SETUP: begin
            if (clk_en) w_next = S_ACCESS;
         end
         S_ACCESS: begin
            if (clk_en) begin
               if (PREADY) begin
                  w_done = 1'b1;
                  w_next = S_RESP;
               end else if (HAS_TO && (r_cnt == TO_LAST)) begin
                  w_to   = 1'b1;
                  w_next = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) begin
         r_pwrite <= 1'b0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_pprot  <= '0;
         r_pauser <= '0;
      end else if (w_accept) begin
         r_pwrite <= cmd_write;
         r_paddr  <= cmd_addr;
         r_pwdata <= cmd_wdata;
         r_pprot  <= cmd_pprot;
         r_pauser <= cmd_pauser;
      end
   end

   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (r_state == S_SETUP) begin
         r_cnt <= '0;
      end else if ((r_state == S_ACCESS) && clk_en && !PREADY) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) begin
         r_rdata   <= '0;
         r_slverr  <= 1'b0;
         r_timeout <= 1'b0;
      end else if (w_done) begin
         r_rdata   <= r_pwrite ? '0 : PRDATA;
         r_slverr  <= PSLVERR;
         r_timeout <= 1'b0;
      end else if (w_to) begin
         r_rdata   <= '0;
         r_slverr  <= 1'b1;
         r_timeout <= 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) begin
         r_err <= '0;
      end else if (((w_done && PSLVERR) || w_to) && (r_err != 8'hFF)) begin
         r_err <= r_err + 8'd1;
      end
   end

   assign cmd_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign PSEL        = (r_state == S_SETUP) || (r_state == S_ACCESS);
   assign PENABLE     = (r_state == S_ACCESS);
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PWDATA      = r_pwdata;
   assign PPROT       = r_pprot;
   assign PAUSER      = r_pauser;
   assign rsp_valid   = (r_state == S_RESP);
   assign rsp_rdata   = rsp_valid ? r_rdata : '0;
   assign rsp_slverr  = rsp_valid & r_slverr;
   assign rsp_timeout = rsp_valid & r_timeout;
   assign err_count   = r_err;

endmodule
